regfile: RTL
============

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32, sets the register width in bits.
REQ-002 Parameter BYPASS, default 1, selects the read path: 1 = same-cycle write-to-read forwarding, 0 = no forwarding.
REQ-003 clk_i  input  1  single clock for the block; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk_i.
REQ-005 rs1_addr_i  input  5  read port 1 register index.
REQ-006 rs2_addr_i  input  5  read port 2 register index.
REQ-007 rs1_data_o  output  DATA_W  read port 1 data; drives the rs1 operand of the execute-stage logic units.
REQ-008 rs2_data_o  output  DATA_W  read port 2 data; drives the rs2 operand of the execute-stage logic units.
REQ-009 rd_wren_i  input  1  write enable for the write port.
REQ-010 rd_addr_i  input  5  write port register index.
REQ-011 rd_data_i  input  DATA_W  write data; the result fed back from the execute stage.
REQ-012 ready_o  output  1  high once initialisation clear is complete and ports are usable.

Function
REQ-013 Storage SHALL be 31 registers, x1..x31, each DATA_W bits; x0 SHALL have no storage.
REQ-014 A read of index 0 SHALL return 0 on either port in all states.
REQ-015 Reads SHALL be combinational from the address inputs, with zero-cycle latency.
REQ-016 A write SHALL occur on the rising edge when rd_wren_i=1, ready_o=1 and rd_addr_i!=0, and becomes visible from the next cycle.
REQ-017 Writes to index 0 SHALL be discarded.
REQ-018 Writes while ready_o=0 SHALL be discarded.
REQ-019 With BYPASS=1, a port whose address equals rd_addr_i SHALL output rd_data_i in the same cycle when rd_wren_i=1, ready_o=1 and the address is not 0.
REQ-020 With BYPASS=0, a port reading the address being written SHALL output the old stored value until the edge.
REQ-021 When rs1_addr_i equals rs2_addr_i, both ports SHALL output identical data, including any bypassed value.
REQ-022 The FSM SHALL have two states, CLEAR and READY, and a 5-bit clear counter clr_cnt.
REQ-023 In CLEAR, each rising edge with rst_ni=1 SHALL write 0 to x[clr_cnt] and increment clr_cnt.
REQ-024 The transition CLEAR->READY SHALL occur on the edge that clears x31; x1..x31 are cleared in exactly 31 cycles.
REQ-025 ready_o SHALL be 0 in CLEAR and 1 in READY, and SHALL be registered.
REQ-026 While ready_o=0, rs1_data_o and rs2_data_o SHALL be forced to 0 and bypass SHALL be inactive.
REQ-027 READY SHALL be held until reset; there is no other exit from READY.
REQ-028 Register contents SHALL change only by the CLEAR sequence or by qualified writes.

Reset
REQ-029 An edge with rst_ni=0 SHALL set state=CLEAR, clr_cnt=1 and ready_o=0, and outputs SHALL read 0.
REQ-030 Reset asserted mid-CLEAR or in READY SHALL restart the clear sequence from x1 on the next rst_ni=1 edge.
REQ-031 ready_o SHALL rise on the 31st rising edge after rst_ni returns high.
REQ-032 Any write presented on the reset edge SHALL be discarded.

Verification
REQ-033 Reset sequence: hold rst_ni=0 for 2 edges, then release -> ready_o=0 for 30 edges and 1 after the 31st; every read of x0..x31 = 0.
REQ-034 Write/read: write x5=0xDEADBEEF, then set rs1_addr_i=5 and rs2_addr_i=5 on the next cycle -> both ports read 0xDEADBEEF.
REQ-035 Zero register: write x0=0xFFFFFFFF -> reading x0 returns 0 on both ports; all other registers are unchanged.
REQ-036 Bypass: BYPASS=1, write x7=0x12345678 with rs1_addr_i=7 in the same cycle -> rs1_data_o=0x12345678 that cycle; with BYPASS=0 -> old value that cycle, new value the next cycle.
REQ-037 Write during CLEAR: assert rd_wren_i for x3=0xA5A5A5A5 at cycle 10 after release -> after ready_o=1, x3 reads 0.
REQ-038 Mid-operation reset: write x31=0x1, pulse rst_ni=0 for 1 edge -> ready_o=0 immediately; after 31 edges ready_o=1 and x31 reads 0.

Source files
------------

// File: rtl/regfile_if.sv
// Register-file port bundle: two combinational read ports, one write port
// and the ready flag. The master drives addresses and write data; the
// register file (slave) returns read data and ready.
interface regfile_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        rs1_addr_i;
  logic [4:0]        rs2_addr_i;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic              rd_wren_i;
  logic [4:0]        rd_addr_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              ready_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rd_wren_i, rd_addr_i, rd_data_i,
    input  rs1_data_o, rs2_data_o, ready_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rd_wren_i, rd_addr_i, rd_data_i,
    output rs1_data_o, rs2_data_o, ready_o
  );
endinterface

// File: rtl/regfile.sv
// 31 x DATA_W register file (x0 hard-wired to zero) with two combinational
// read ports, one write port, optional write-to-read forwarding and a
// post-reset clear sequence that zeroes x1..x31 one register per cycle.
module regfile #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input logic     clk_i,
  input logic     rst_ni,
  regfile_if.slave bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        clr_cnt_q, clr_cnt_d;
  logic              clr_we;
  logic              ready;
  logic              wr_ok;
  logic              fwd_en;
  logic              mem_we;
  logic [4:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  // x1..x31 only; x0 has no storage and is synthesised as constant zero.
  logic [DATA_W-1:0] mem_q [1:31];

  // ready comes straight from the state flop, so it is registered.
  assign ready  = (state_q == ST_READY);
  assign wr_ok  = ready && bus.rd_wren_i && (bus.rd_addr_i != 5'd0);
  assign fwd_en = (BYPASS != 0) && wr_ok;

  // State and clear-counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= 5'd1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: walk clr_cnt from 1 to 31, leave CLEAR on x31.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Storage write mux: clear sequence or qualified port write, never on a reset edge.
  always_comb begin
    mem_we    = rst_ni && (clr_we || wr_ok);
    mem_waddr = clr_we ? clr_cnt_q : bus.rd_addr_i;
    mem_wdata = clr_we ? '0 : bus.rd_data_i;
  end

  // Register storage; contents are initialised by the clear sequence.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset branch on purpose; a reset on every bit
    // would block RAM inference, and the CLEAR walk provides known values.
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports: zero when not ready or x0, forwarded data on an address hit.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (ready && (bus.rs1_addr_i != 5'd0)) begin
      rs1_data = mem_q[bus.rs1_addr_i];
      if (fwd_en && (bus.rs1_addr_i == bus.rd_addr_i)) begin
        rs1_data = bus.rd_data_i;
      end
    end
    if (ready && (bus.rs2_addr_i != 5'd0)) begin
      rs2_data = mem_q[bus.rs2_addr_i];
      if (fwd_en && (bus.rs2_addr_i == bus.rd_addr_i)) begin
        rs2_data = bus.rd_data_i;
      end
    end
  end

  assign bus.rs1_data_o = rs1_data;
  assign bus.rs2_data_o = rs2_data;
  assign bus.ready_o    = ready;

endmodule
